// File: rtl/decrypt_depad_seq.sv
// Recovers the LFSR seed/tap from an all-space preamble, then decrypts and left-compacts the
// message in data memory, space-padding the tail. Build option: DECRYPT_PARITY_EN.
module decrypt_depad_seq #(
  parameter int MSG_BASE = 64,
  parameter int OUT_BASE = 0,
  parameter int MSG_LEN  = 64,
  parameter int CHK_LEN  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic       Err,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);

  // state   | meaning
  // IDLE    | waiting for Start sampled 1 then 0
  // SEED    | reading preamble byte 0 to recover the seed
  // SEARCH  | trying candidate taps against preamble bytes 1..CHK_LEN-1
  // DECRYPT | reading and decrypting message byte j
  // WRITE   | write strobe for one kept byte
  // PAD     | filling the tail with spaces
  // DONE    | Ack high until Start re-asserts
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEED    = 3'd1;
  localparam logic [2:0] S_SEARCH  = 3'd2;
  localparam logic [2:0] S_DECRYPT = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_PAD     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [7:0] MSG_BASE_B = 8'(MSG_BASE);
  localparam logic [7:0] OUT_BASE_B = 8'(OUT_BASE);
  localparam logic [7:0] LEN_B      = 8'(MSG_LEN);
  localparam logic [3:0] CHK_LAST   = 4'(CHK_LEN - 1);
  localparam logic [3:0] LAST_TAP   = 4'd8;
  localparam logic [6:0] SPACE7     = 7'h20;

  function automatic logic [6:0] tap_of(input logic [3:0] idx);
    logic [6:0] t;
    case (idx)
      4'd0:    t = 7'h60;
      4'd1:    t = 7'h48;
      4'd2:    t = 7'h78;
      4'd3:    t = 7'h72;
      4'd4:    t = 7'h6A;
      4'd5:    t = 7'h69;
      4'd6:    t = 7'h5C;
      4'd7:    t = 7'h7E;
      4'd8:    t = 7'h7B;
      default: t = 7'h60;
    endcase
    return t;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  logic [2:0] state_q, state_d;
  logic       ph_q, ph_d;
  logic       start_q, start_d;
  logic [6:0] seed_q, seed_d;
  logic [6:0] s_q, s_d;
  logic [6:0] tap_q, tap_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [3:0] i_q, i_d;
  logic [3:0] k_q, k_d;
  logic [7:0] j_q, j_d;
  logic [7:0] wp_q, wp_d;
  logic       lead_q, lead_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [6:0] rd7;
  logic [6:0] plain;
  logic       perr;
  logic       skip;

  assign rd7   = mem_rd_data[6:0];
  assign plain = rd7 ^ lfsr_q;

`ifdef DECRYPT_PARITY_EN
  // Encrypted bytes carry even parity; a parity hit always ends the leading-space skip.
  assign perr = ^mem_rd_data;
  assign skip = lead_q && (plain == SPACE7) && !perr;
`else
  logic rd_par_unused;
  assign rd_par_unused = mem_rd_data[7];
  assign perr = 1'b0;
  assign skip = lead_q && (plain == SPACE7);
`endif

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    start_d   = Start;
    seed_d    = seed_q;
    s_d       = s_q;
    tap_d     = tap_q;
    lfsr_d    = lfsr_q;
    i_d       = i_q;
    k_d       = k_q;
    j_d       = j_q;
    wp_d      = wp_q;
    lead_d    = lead_q;
    ack_d     = ack_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start_q && !Start) begin
          state_d = S_SEED;
          ph_d    = 1'b0;
          addr_d  = MSG_BASE_B;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_SEED: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          seed_d  = rd7 ^ SPACE7;
          k_d     = 4'd0;
          i_d     = 4'd1;
          s_d     = lfsr_step(rd7 ^ SPACE7, tap_of(4'd0));
          state_d = S_SEARCH;
          ph_d    = 1'b0;
          addr_d  = MSG_BASE_B + 8'd1;
        end
      end

      S_SEARCH: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if ((rd7 ^ SPACE7) == s_q) begin
            if (i_q == CHK_LAST) begin
              tap_d   = tap_of(k_q);
              state_d = S_DECRYPT;
              j_d     = 8'd0;
              wp_d    = 8'd0;
              lfsr_d  = seed_q;
              lead_d  = 1'b1;
              addr_d  = MSG_BASE_B;
            end else begin
              i_d    = i_q + 4'd1;
              s_d    = lfsr_step(s_q, tap_of(k_q));
              addr_d = MSG_BASE_B + {4'd0, i_q} + 8'd1;
            end
          end else if (k_q == LAST_TAP) begin
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            k_d    = k_q + 4'd1;
            i_d    = 4'd1;
            s_d    = lfsr_step(seed_q, tap_of(k_q + 4'd1));
            addr_d = MSG_BASE_B + 8'd1;
          end
        end
      end

      S_DECRYPT: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d   = 1'b0;
          lfsr_d = lfsr_step(lfsr_q, tap_q);
          j_d    = j_q + 8'd1;
          if (skip) begin
            if (j_q == LEN_B - 8'd1) begin
              state_d = S_PAD;
            end else begin
              addr_d = MSG_BASE_B + j_q + 8'd1;
            end
          end else begin
            lead_d    = 1'b0;
            state_d   = S_WRITE;
            addr_d    = OUT_BASE_B + wp_q;
            wr_en_d   = 1'b1;
            wr_data_d = {perr, plain};
          end
        end
      end

      // j has already advanced, so wp stays strictly behind the read pointer.
      S_WRITE: begin
        wp_d = wp_q + 8'd1;
        if (j_q == LEN_B) begin
          state_d = S_PAD;
        end else begin
          state_d = S_DECRYPT;
          ph_d    = 1'b0;
          addr_d  = MSG_BASE_B + j_q;
        end
      end

      S_PAD: begin
        if (wp_q == LEN_B) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
        end else begin
          addr_d    = OUT_BASE_B + wp_q;
          wr_en_d   = 1'b1;
          wr_data_d = {1'b0, SPACE7};
          wp_d      = wp_q + 8'd1;
        end
      end

      S_DONE: begin
        if (Start) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      ph_q      <= 1'b0;
      start_q   <= 1'b0;
      seed_q    <= 7'd0;
      s_q       <= 7'd0;
      tap_q     <= 7'd0;
      lfsr_q    <= 7'd0;
      i_q       <= 4'd0;
      k_q       <= 4'd0;
      j_q       <= 8'd0;
      wp_q      <= 8'd0;
      lead_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      start_q   <= start_d;
      seed_q    <= seed_d;
      s_q       <= s_d;
      tap_q     <= tap_d;
      lfsr_q    <= lfsr_d;
      i_q       <= i_d;
      k_q       <= k_d;
      j_q       <= j_d;
      wp_q      <= wp_d;
      lead_q    <= lead_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign Ack         = ack_q;
  assign Err         = err_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_decrypt_depad_seq.sv
// Self-checking bench for decrypt_depad_seq: 256-byte memory model plus a behavioural
// encrypt/search/depad reference model; directed scenarios then randomized runs.
`timescale 1ns/1ps
module tb_decrypt_depad_seq;

  localparam int MSG_BASE = 64;
  localparam int OUT_BASE = 0;
  localparam int MSG_LEN  = 64;
  localparam int CHK_LEN  = 10;
  localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       Err;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;

  logic [7:0] mem     [0:255];
  logic [7:0] img     [0:255];
  logic [7:0] exp_mem [0:255];
  logic [6:0] pt      [0:63];
  logic       load;
  logic       exp_err;
  int         exp_idx;
  int         n_vec;
  int         n_err;

  decrypt_depad_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Err(Err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (load) begin
      for (int a = 0; a < 256; a++) mem[a] <= img[a];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_addr];
  end

  function automatic logic [6:0] ref_step(input logic [6:0] s, input logic [6:0] t);
    int fb;
    fb = $countones(s & t) % 2;
    return 7'(((int'(s) * 2) % 128) + fb);
  endfunction

  function automatic int mem_diff(output int first);
    int bad;
    bad = 0;
    first = 0;
    for (int a = 255; a >= 0; a--) begin
      if (mem[a] !== exp_mem[a]) begin
        bad++;
        first = a;
      end
    end
    return bad;
  endfunction

  task automatic build_image(input logic [6:0] tap, input logic [6:0] seed,
                             input int flip_pos, input int flip_bit);
    logic [6:0] lf;
    logic [7:0] e;
    for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
    lf = seed;
    for (int j = 0; j < MSG_LEN; j++) begin
      e = {1'b0, pt[j] ^ lf};
      e[7] = ^e[6:0];
      if (j == flip_pos) e[flip_bit] = ~e[flip_bit];
      img[MSG_BASE + j] = e;
      lf = ref_step(lf, tap);
    end
  endtask

  task automatic load_image();
    @(negedge Clk);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
  endtask

  task automatic ref_model();
    logic [6:0] seed, s, lf, plain;
    logic       perr, lead, ok;
    logic [7:0] q [$];
    for (int a = 0; a < 256; a++) exp_mem[a] = img[a];
    seed = img[MSG_BASE][6:0] ^ 7'h20;
    exp_idx = -1;
    for (int k = 0; k < 9 && exp_idx < 0; k++) begin
      s = seed;
      ok = 1'b1;
      for (int i = 1; i < CHK_LEN; i++) begin
        s = ref_step(s, TAPS[k]);
        if ((img[MSG_BASE + i][6:0] ^ 7'h20) != s) ok = 1'b0;
      end
      if (ok) exp_idx = k;
    end
    exp_err = (exp_idx < 0);
    if (!exp_err) begin
      lf = seed;
      lead = 1'b1;
      for (int j = 0; j < MSG_LEN; j++) begin
        plain = img[MSG_BASE + j][6:0] ^ lf;
`ifdef DECRYPT_PARITY_EN
        perr = ^img[MSG_BASE + j];
`else
        perr = 1'b0;
`endif
        if (!(lead && plain == 7'h20 && !perr)) begin
          lead = 1'b0;
          q.push_back({perr, plain});
        end
        lf = ref_step(lf, TAPS[exp_idx]);
      end
      for (int a = 0; a < MSG_LEN; a++) exp_mem[OUT_BASE + a] = (a < q.size()) ? q[a] : 8'h20;
    end
  endtask

  task automatic wait_ack(input bit toggle, output int wcnt, output int a1cnt);
    int  cyc;
    bit  done;
    wcnt = 0;
    a1cnt = 0;
    done = 1'b0;
    for (cyc = 0; cyc < 800 && !done; cyc++) begin
      @(negedge Clk);
      if (mem_wr_en) wcnt++;
      if (mem_addr == 8'(MSG_BASE + 1)) a1cnt++;
      if (toggle && cyc == 5) Start = 1'b1;
      if (toggle && cyc == 8) Start = 1'b0;
      if (Ack) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL ack_timeout: Ack=%b after %0d cycles, required 1", Ack, cyc);
    end
  endtask

  task automatic launch_and_wait(input bit toggle, output int wcnt, output int a1cnt);
    Start = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    wait_ack(toggle, wcnt, a1cnt);
  endtask

  task automatic gen_msg(input int nlead);
    for (int j = 0; j < MSG_LEN; j++) begin
      if (j < nlead || $urandom_range(3, 0) == 0) pt[j] = 7'h20;
      else pt[j] = 7'($urandom_range(126, 33));
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge Clk);
    n_vec++; if (Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", Ack); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", Err); end
    n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %02h want 00", mem_addr); end
    n_vec++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", mem_wr_en); end
    n_vec++; if (mem_wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %02h want 00", mem_wr_data); end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic ajok_text();
    for (int j = 0; j < MSG_LEN; j++) pt[j] = 7'h20;
    pt[10] = 7'h41; pt[11] = 7'h6A; pt[12] = 7'h6F; pt[13] = 7'h6B;
  endtask

  task automatic test_ajok();
    int wcnt, a1, bad, first, sp_bad;
    logic [7:0] want [4];
    want = '{8'h41, 8'h6A, 8'h6F, 8'h6B};
    ajok_text();
    build_image(7'h69, 7'h01, -1, 0);
    load_image();
    ref_model();
    launch_and_wait(1'b0, wcnt, a1);
    n_vec++; if (Ack !== 1'b1) begin n_err++; $display("FAIL ajok_ack: got %b want 1", Ack); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL ajok_err: got %b want 0", Err); end
    n_vec++; if (wcnt != MSG_LEN) begin n_err++; $display("FAIL ajok_writes: got %0d want %0d", wcnt, MSG_LEN); end
    for (int a = 0; a < 4; a++) begin
      n_vec++;
      if (mem[a] !== want[a]) begin n_err++; $display("FAIL ajok_byte%0d: got %02h want %02h", a, mem[a], want[a]); end
    end
    sp_bad = 0;
    for (int a = 4; a < MSG_LEN; a++) if (mem[a] !== 8'h20) sp_bad++;
    n_vec++; if (sp_bad != 0) begin n_err++; $display("FAIL ajok_pad: %0d bytes not 20, want 0", sp_bad); end
    bad = mem_diff(first);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL ajok_mem: %0d bytes differ, first %0d got %02h want %02h", bad, first, mem[first], exp_mem[first]); end
  endtask

  task automatic test_parity_flip();
    int wcnt, a1, bad, first;
    logic [7:0] want1;
`ifdef DECRYPT_PARITY_EN
    want1 = 8'hEA;
`else
    want1 = 8'h6A;
`endif
    ajok_text();
    build_image(7'h69, 7'h01, 11, 7);
    load_image();
    ref_model();
    launch_and_wait(1'b0, wcnt, a1);
    n_vec++; if (mem[1] !== want1) begin n_err++; $display("FAIL parity_byte1: got %02h want %02h", mem[1], want1); end
    n_vec++; if (mem[0] !== 8'h41 || mem[2] !== 8'h6F || mem[3] !== 8'h6B) begin
      n_err++; $display("FAIL parity_neighbours: got %02h %02h %02h want 41 6F 6B", mem[0], mem[2], mem[3]); end
    bad = mem_diff(first);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL parity_mem: %0d bytes differ, first %0d got %02h want %02h", bad, first, mem[first], exp_mem[first]); end
  endtask

  task automatic test_all_space();
    int wcnt, a1, sp_bad;
    for (int j = 0; j < MSG_LEN; j++) pt[j] = 7'h20;
    build_image(7'h48, 7'h7F, -1, 0);
    load_image();
    ref_model();
    launch_and_wait(1'b0, wcnt, a1);
    sp_bad = 0;
    for (int a = 0; a < MSG_LEN; a++) if (mem[OUT_BASE + a] !== 8'h20) sp_bad++;
    n_vec++; if (sp_bad != 0) begin n_err++; $display("FAIL allsp_out: %0d bytes not 20, want 0", sp_bad); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL allsp_err: got %b want 0", Err); end
    n_vec++; if (wcnt != MSG_LEN) begin n_err++; $display("FAIL allsp_writes: got %0d want %0d", wcnt, MSG_LEN); end
    // byte 1 is read once per tried candidate plus once when decrypting, 2 cycles each
    n_vec++; if (a1 != 6) begin n_err++; $display("FAIL allsp_search: byte1 address cycles %0d want 6", a1); end
  endtask

  task automatic test_no_match();
    int wcnt, a1, bad, first;
    logic [6:0] seed, v;
    logic [7:0] e;
    for (int j = 0; j < MSG_LEN; j++) pt[j] = 7'h20;
    seed = 7'h2A;
    build_image(7'h60, seed, -1, 0);
    v = {~seed[5], seed[4:0], 1'b0};
    e = {1'b0, v ^ 7'h20};
    e[7] = ^e[6:0];
    img[MSG_BASE + 1] = e;
    load_image();
    ref_model();
    launch_and_wait(1'b0, wcnt, a1);
    n_vec++; if (Ack !== 1'b1) begin n_err++; $display("FAIL nomatch_ack: got %b want 1", Ack); end
    n_vec++; if (Err !== 1'b1) begin n_err++; $display("FAIL nomatch_err: got %b want 1", Err); end
    n_vec++; if (wcnt != 0) begin n_err++; $display("FAIL nomatch_writes: got %0d want 0", wcnt); end
    bad = mem_diff(first);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL nomatch_mem: %0d bytes differ, first %0d got %02h want %02h", bad, first, mem[first], exp_mem[first]); end
  endtask

  task automatic test_reset_mid();
    int  wcnt, a1, bad, first, stray;
    bit  seen;
    gen_msg(12);
    pt[20] = 7'h51;
    build_image(TAPS[$urandom_range(8, 0)], 7'($urandom), -1, 0);
    load_image();
    ref_model();
    Start = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 800 && !seen; c++) begin
      @(negedge Clk);
      if (mem_wr_en) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rstmid_nowrite: write strobe never seen, want one"); end
    Reset = 1'b0;
    #1;
    n_vec++; if (mem_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wren: got %b want 0", mem_wr_en); end
    n_vec++; if (Ack !== 1'b0) begin n_err++; $display("FAIL rstmid_ack: got %b want 0", Ack); end
    stray = 0;
    Start = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      if (mem_wr_en || Ack) stray++;
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL rstmid_quiet: %0d active cycles in reset, want 0", stray); end
    Reset = 1'b1;
    @(negedge Clk);
    launch_and_wait(1'b0, wcnt, a1);
    n_vec++; if (Err !== exp_err) begin n_err++; $display("FAIL rstmid_err: got %b want %b", Err, exp_err); end
    bad = mem_diff(first);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstmid_mem: %0d bytes differ, first %0d got %02h want %02h", bad, first, mem[first], exp_mem[first]); end
  endtask

  task automatic test_ack_handshake();
    int wcnt, a1, drops, busy, bad, first;
    drops = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Ack !== 1'b1) drops++;
    end
    n_vec++; if (drops != 0) begin n_err++; $display("FAIL ack_hold: Ack low in %0d cycles, want 0", drops); end
    Start = 1'b1;
    @(negedge Clk);
    n_vec++; if (Ack !== 1'b0) begin n_err++; $display("FAIL ack_fall: got %b want 0", Ack); end
    gen_msg(CHK_LEN);
    build_image(TAPS[$urandom_range(8, 0)], 7'($urandom), -1, 0);
    busy = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) load_image();
      @(negedge Clk);
      if (Ack || mem_wr_en || mem_addr != 8'(OUT_BASE + MSG_LEN - 1)) busy++;
    end
    n_vec++; if (busy != 0) begin n_err++; $display("FAIL ack_idle: %0d non-idle cycles, want 0", busy); end
    ref_model();
    Start = 1'b0;
    @(negedge Clk);
    n_vec++; if (mem_addr !== 8'(MSG_BASE)) begin n_err++; $display("FAIL ack_relaunch: addr %02h want %02h", mem_addr, 8'(MSG_BASE)); end
    wait_ack(1'b0, wcnt, a1);
    bad = mem_diff(first);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL ack_mem: %0d bytes differ, first %0d got %02h want %02h", bad, first, mem[first], exp_mem[first]); end
  endtask

  task automatic test_random();
    int wcnt, a1, bad, first, fpos, fbit;
    for (int r = 0; r < 8; r++) begin
      gen_msg((r == 0) ? MSG_LEN : $urandom_range(40, CHK_LEN));
      fpos = ($urandom_range(1, 0) == 1) ? $urandom_range(MSG_LEN - 1, CHK_LEN) : -1;
      fbit = $urandom_range(7, 0);
      build_image(TAPS[$urandom_range(8, 0)], 7'($urandom), fpos, fbit);
      load_image();
      ref_model();
      launch_and_wait(1'b1, wcnt, a1);
      n_vec++; if (Err !== exp_err) begin n_err++; $display("FAIL rand%0d_err: got %b want %b", r, Err, exp_err); end
      n_vec++; if (wcnt != (exp_err ? 0 : MSG_LEN)) begin n_err++; $display("FAIL rand%0d_writes: got %0d want %0d", r, wcnt, exp_err ? 0 : MSG_LEN); end
      bad = mem_diff(first);
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d_mem: %0d bytes differ, first %0d got %02h want %02h", r, bad, first, mem[first], exp_mem[first]); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_ajok();
    test_parity_flip();
    test_all_space();
    test_no_match();
    test_reset_mid();
    test_ack_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decrypt_depad_seq.md
Name: decrypt_depad_seq

Overview:
- Hardware sequencer for the program-3 decrypt/depad flow.
- Reads 64 encrypted, parity-tagged bytes from data memory and recovers the LFSR seed and tap pattern from the guaranteed all-space preamble.
- Decrypts every byte, flags parity errors, strips leading spaces, writes the compacted message back to data memory and pads the tail with spaces.
- Sits beside the data memory and owns its single port while running; raises Ack when finished.

Parameters:
- MSG_BASE, 64, first address of encrypted input bytes
- OUT_BASE, 0, first address of decrypted output bytes
- MSG_LEN, 64, number of input bytes processed and output bytes written
- CHK_LEN, 10, preamble bytes used for tap search (byte 0 seeds, bytes 1..CHK_LEN-1 verify)

Ports:
- Clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  high holds the block idle; a high-to-low transition launches one run
- Ack  output  1  run complete; held high until Start re-asserts
- Err  output  1  no candidate tap pattern matched the preamble; valid while Ack=1
- mem_addr  output  8  data memory address
- mem_wr_en  output  1  write strobe, one cycle per byte
- mem_wr_data  output  8  write data
- mem_rd_data  input  8  read data, valid one cycle after mem_addr is presented

Behaviour:
- Reset (Reset=0, async) clears all outputs: Ack=0, Err=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0.
  - State goes to IDLE and all counters clear.
  - Reset mid-run aborts the run immediately; no further writes occur.
- Candidate taps, fixed order, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: next = {s[5:0], ^(s & tap)}. All state is 7 bits.
- Every read costs 2 cycles: address cycle, then data cycle.
- States:
  - IDLE: waits for Start sampled 1 then 0 on consecutive edges, then goes to SEED.
  - SEED: reads MSG_BASE; seed = rd[6:0] ^ 0x20. Goes to SEARCH with k=0, i=1, s=step(seed, tap[k]).
  - SEARCH: reads MSG_BASE+i and compares rd[6:0] ^ 0x20 against s.
    - Match, i<CHK_LEN-1: i++, s=step(s).
    - Match, i=CHK_LEN-1: latch tap[k] and go to DECRYPT.
    - Mismatch: k++, i=1, s=step(seed, tap[k]).
    - Mismatch with k=8: set Err and go to DONE.
  - DECRYPT: j=0..MSG_LEN-1, with lfsr starting from seed.
    - Read MSG_BASE+j.
    - plain = rd[6:0] ^ lfsr.
    - perr = ^rd[7:0]; odd parity across all 8 bits means an error.
    - While the leading flag is set, a byte with plain=0x20 and perr=0 is skipped (no write).
    - Any other byte clears the leading flag and is written to OUT_BASE+wp as {perr, plain}; then wp++.
    - Decrypt, skip and write take 3 cycles per written byte and 2 per skipped byte. lfsr steps once per byte.
  - PAD: writes 0x20 to OUT_BASE+wp, wp++, until wp=MSG_LEN; then DONE.
  - DONE: Ack=1. Returns to IDLE when Start=1.
- wp never exceeds j, so output writes cannot overtake unread input even when OUT_BASE overlaps MSG_BASE.
- All-space message: every byte is skipped and PAD writes all 64 bytes with 0x20.
- Err=1 path writes nothing to memory.
- Start re-asserted mid-run is ignored until DONE.
- Worst-case run length is under 420 cycles after launch.

Optional Feature:
- DECRYPT_PARITY_EN
- Defined: output bit7 = perr as above, and a parity-error byte always ends the leading-space skip.
- Undefined: parity is not computed; output bit7 = 0; skip test is plain=0x20 only.

Test Plan:
- tap 0x69, seed 0x01, pad length 10, message "Ajok" with leading spaces, no flips -> mem[0..3] = 0x41, 0x6A, 0x6F, 0x6B; mem[4..63] = 0x20; Ack=1, Err=0.
- Same setup with one bit flipped in the encrypted byte holding 'j' -> that output byte has bit7=1; all other bytes unchanged (DECRYPT_PARITY_EN defined).
- tap 0x48 (index 1), seed 0x7F, all-space message -> mem[0..63] = 0x20; search selects index 1 after one rejected candidate.
- Preamble corrupted so no tap matches -> Err=1, Ack=1, mem[0..63] untouched.
- Reset pulled low during DECRYPT -> Ack=0, mem_wr_en=0 immediately; a fresh Start falling edge reruns with correct output.
- Ack held while Start=0; Start raised -> Ack falls next cycle and the block sits idle until the next falling edge.
